// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - one-hot multi-phase enable sequencer for the accumulator datapath
module phase_sequencer #(
    parameter int NUM_PHASES = 2,
    parameter int LOOP_WIDTH = 8
) (
    input  logic                  CLKb,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LOOP_WIDTH-1:0] loop_count,
    input  logic                  step_mode,
    input  logic                  step,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic                  enA,
    output logic                  enALU,
    output logic                  enC,
    output logic [2:0]            phase,
    output logic [LOOP_WIDTH-1:0] iter_count,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);

    state_t                state_q, state_d;
    logic [2:0]            phase_q, phase_d;
    logic [LOOP_WIDTH-1:0] iter_q, iter_d;
    logic [LOOP_WIDTH-1:0] lc_q, lc_d;
    logic [LOOP_WIDTH-1:0] iter_inc;
    logic                  pass_end;

    // All state moves on the falling edge; reset clears everything at once.
    always_ff @(negedge CLKb or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            iter_q  <= '0;
            lc_q    <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            iter_q  <= iter_d;
            lc_q    <= lc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        iter_d   = iter_q;
        lc_d     = lc_q;
        pass_end = (phase_q == LAST_PHASE);
        iter_inc = iter_q + LOOP_WIDTH'(1);

        if (abort) begin
            // iter_count is kept so software can see how far an aborted run got.
            state_d = S_IDLE;
            phase_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        lc_d    = loop_count;
                        phase_d = '0;
                        iter_d  = '0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (pass_end) begin
                        phase_d = '0;
                        iter_d  = iter_inc;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                    if (pass_end && (lc_q != '0) && (iter_inc == lc_q)) begin
                        state_d = S_DONE;
                    end else if (step_mode) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_HOLD: begin
                    if (step || !step_mode) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        phase_en = '0;
        if (state_q == S_RUN) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                phase_en[i] = (phase_q == 3'(i));
            end
        end
    end

    assign enA        = phase_en[0];
    assign enALU      = phase_en[0];
    assign enC        = phase_en[NUM_PHASES-1];
    assign phase      = phase_q;
    assign iter_count = iter_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_HOLD);
    assign done       = (state_q == S_DONE);

endmodule
